// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, port id, requester count.
// Optional feature macro: DMEM_ARB_LOCK_EN (locked RMW sequences).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam int NREQ = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory bus for dmem_arbiter.
// DMEM_ARB_LOCK_EN adds the per-port lock input.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [AW-1:0]   addr0;
  logic [AW-1:0]   addr1;
  logic [DW-1:0]   wdata0;
  logic [DW-1:0]   wdata1;
  logic [NREQ-1:0] ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_di;
  logic [DW-1:0]   mem_dout;
`ifdef DMEM_ARB_LOCK_EN
  logic [NREQ-1:0] lock;

  modport master (
    output req, we, addr0, addr1,
    output wdata0, wdata1, lock,
    input  ack, rdata, busy,
    input  mem_we, mem_addr, mem_di,
    output mem_dout
  );

  modport slave (
    input  req, we, addr0, addr1,
    input  wdata0, wdata1, lock,
    output ack, rdata, busy,
    output mem_we, mem_addr, mem_di,
    input  mem_dout
  );
`else
  modport master (
    output req, we, addr0, addr1,
    output wdata0, wdata1,
    input  ack, rdata, busy,
    input  mem_we, mem_addr, mem_di,
    output mem_dout
  );

  modport slave (
    input  req, we, addr0, addr1,
    input  wdata0, wdata1,
    output ack, rdata, busy,
    output mem_we, mem_addr, mem_di,
    input  mem_dout
  );
`endif

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-port picker, prio breaks ties.
// DMEM_ARB_LOCK_EN restricts the pick to the owner while locked.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  port_id_t        i_prio,
`ifdef DMEM_ARB_LOCK_EN
  input  logic            i_locked,
  input  port_id_t        i_owner,
`endif
  output logic            o_valid,
  output port_id_t        o_winner
);

  logic [NREQ-1:0] w_req;

  // mask the other port while a lock is held
  always_comb begin
    w_req = i_req;
`ifdef DMEM_ARB_LOCK_EN
    if (i_locked) begin
      w_req = i_owner ? (i_req & 2'b10)
                      : (i_req & 2'b01);
    end
`endif
  end

  // single requester wins outright, ties go to prio
  always_comb begin
    o_valid  = |w_req;
    o_winner = i_prio;
    unique case (1'b1)
      (w_req == 2'b01): o_winner = 1'b0;
      (w_req == 2'b10): o_winner = 1'b1;
      default:          o_winner = i_prio;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of a 256x8 data memory port.
// DMEM_ARB_LOCK_EN enables owner locking for atomic RMW.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  arb_state_t r_state;
  arb_state_t w_next;

  port_id_t      r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  port_id_t      r_prio;

  logic          w_valid;
  port_id_t      w_winner;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  logic          w_grant;

  logic [NREQ-1:0] w_ack;
  logic            w_mem_we;

`ifdef DMEM_ARB_LOCK_EN
  logic r_lock;
  logic r_locked;
`endif

  rr_arb2 u_pick (
    .i_req    (bus.req),
    .i_prio   (r_prio),
`ifdef DMEM_ARB_LOCK_EN
    .i_locked (r_locked),
    .i_owner  (r_owner),
`endif
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  // mux the winning port's command
  always_comb begin
    w_win_we    = bus.we[w_winner];
    w_win_addr  = w_winner ? bus.addr1 : bus.addr0;
    w_win_wdata = w_winner ? bus.wdata1 : bus.wdata0;
    w_grant     = (r_state == IDLE) && w_valid;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_valid) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // latch the winning command in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      r_we    <= w_win_we;
      r_addr  <= w_win_addr;
      r_wdata <= w_win_wdata;
    end
  end

  // capture read data at the end of ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == ACCESS && !r_we) begin
      r_rdata <= bus.mem_dout;
    end
  end

  // hand priority to the other port after each completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (r_state == DONE) begin
      r_prio <= ~r_owner;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  // lock bit travels with the command
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= 1'b0;
    end else if (w_grant) begin
      r_lock <= bus.lock[w_winner];
    end
  end

  // locked follows the lock of each completed command
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked <= 1'b0;
    end else if (r_state == DONE) begin
      r_locked <= r_lock;
    end
  end
`endif

  // ack and write strobe, both killed by reset
  always_comb begin
    w_ack = '0;
    if (r_state == DONE && !reset) begin
      w_ack[r_owner] = 1'b1;
    end
    w_mem_we = (r_state == ACCESS) && r_we && !reset;
  end

  assign bus.ack      = w_ack;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != IDLE);
  assign bus.mem_we   = w_mem_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_di   = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus random traffic.
// DMEM_ARB_LOCK_EN enables the lock scenario and random locks.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic       p_req [2];
  logic       p_we  [2];
  logic [7:0] p_addr[2];
  logic [7:0] p_wd  [2];
  logic       p_lock[2];

  assign bus.req    = {p_req[1], p_req[0]};
  assign bus.we     = {p_we[1], p_we[0]};
  assign bus.addr0  = p_addr[0];
  assign bus.addr1  = p_addr[1];
  assign bus.wdata0 = p_wd[0];
  assign bus.wdata1 = p_wd[1];
`ifdef DMEM_ARB_LOCK_EN
  assign bus.lock   = {p_lock[1], p_lock[0]};
`endif

  logic [7:0] mem[256];
  always @(posedge clk)
    if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_di;
  assign bus.mem_dout = mem[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // transaction-level reference: a grant sampled at cycle t0
  // writes/reads memory in t0+1 and acks in t0+2
  logic [7:0] ref_mem[256];
  bit         m_valid = 0;
  bit         pend = 0;
  int         cyc = 0;
  int         t0 = -10;
  port_id_t   m_owner = 0;
  port_id_t   m_prio = 0;
  logic       m_we = 0;
  logic       m_lock = 0;
  logic       m_locked = 0;
  logic [7:0] m_addr = 0;
  logic [7:0] m_wd = 0;
  logic [7:0] m_rd = 0;
  int         we_cnt = 0;
  logic [1:0] ack_log[$];

  always @(negedge clk) begin
    logic [1:0] ea;
    logic [1:0] el;
    logic       ew;
    logic       eb;
    port_id_t   win;
    if (m_valid) begin
      ew = pend && cyc == t0 + 1 && m_we && !reset;
      ea = (pend && cyc == t0 + 2 && !reset)
           ? (2'b01 << m_owner) : 2'b00;
      eb = pend && (cyc == t0 + 1 || cyc == t0 + 2);
      chk("ack", 32'(bus.ack), 32'(ea));
      chk("mem_we", 32'(bus.mem_we), 32'(ew));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("mem_di", 32'(bus.mem_di), 32'(m_wd));
      chk("rdata", 32'(bus.rdata), 32'(m_rd));
      chk("busy", 32'(bus.busy), 32'(eb));
    end
    if (bus.ack != 2'b00) ack_log.push_back(bus.ack);
    if (bus.mem_we === 1'b1) we_cnt++;
    if (reset) begin
      m_valid = 1; pend = 0; m_prio = 0; m_rd = 0;
      m_addr = 0; m_wd = 0; m_we = 0; m_locked = 0;
      m_owner = 0; m_lock = 0;
    end else if (m_valid) begin
      if (pend && cyc == t0 + 1) begin
        if (m_we) ref_mem[m_addr] = m_wd;
        else      m_rd = ref_mem[m_addr];
      end else if (pend && cyc == t0 + 2) begin
        m_prio = ~m_owner;
        m_locked = m_lock;
        pend = 0;
      end else if (!pend) begin
        el = bus.req;
        if (m_locked) el = el & (2'b01 << m_owner);
        if (el != 2'b00) begin
          win = (el == 2'b11) ? m_prio : el[1];
          m_owner = win;
          m_we = bus.we[win];
          m_addr = win ? bus.addr1 : bus.addr0;
          m_wd = win ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_LOCK_EN
          m_lock = bus.lock[win];
`else
          m_lock = 0;
`endif
          pend = 1;
          t0 = cyc;
        end
      end
    end
    cyc++;
  end

  // call just after a posedge; returns just after the ack edge
  task automatic port_do(input int p, input logic w,
                         input logic [7:0] a,
                         input logic [7:0] d, input logic lk,
                         output logic [1:0] ackv,
                         output logic [7:0] rd,
                         output logic [7:0] rd_prev,
                         output int lat);
    bit done = 0;
    p_we[p] = w; p_addr[p] = a; p_wd[p] = d;
    p_lock[p] = lk; p_req[p] = 1'b1;
    ackv = 2'b00; rd = 8'h00; lat = -1;
    rd_prev = bus.rdata;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.ack[p]) begin
        ackv = bus.ack; rd = bus.rdata; lat = n; done = 1;
      end else begin
        rd_prev = bus.rdata;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL port%0d_timeout: got no ack want ack", p);
    end
    @(posedge clk); #1;
  endtask

  task automatic port_idle(input int p);
    p_req[p] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [1:0] av;
    logic [7:0] rd, rp, a;
    int lat, gap;
    logic lk;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        port_idle(p);
        repeat (gap) @(posedge clk);
        #1;
      end
      a = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a | 8'hF8;
      lk = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      if (k < n - 1 && $urandom_range(0, 3) == 0) lk = 1'b1;
`endif
      port_do(p, 1'($urandom_range(0, 1)), a,
              8'($urandom_range(0, 255)), lk,
              av, rd, rp, lat);
    end
    port_idle(p);
  endtask

  initial begin
    logic [1:0] av;
    logic [7:0] rd, rp;
    int lat, wc, nmis;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0;
      p_wd[p] = 0; p_lock[p] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_di", 32'(bus.mem_di), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    wc = we_cnt;
    port_do(0, 1, 8'h10, 8'hA5, 0, av, rd, rp, lat);
    port_idle(0);
    chk("s1_ack", 32'(av), 32'h1);
    chk("s1_lat", 32'(lat), 32'd2);
    chk("s1_we_cycles", 32'(we_cnt - wc), 32'd1);
    port_do(1, 0, 8'h10, 8'h00, 0, av, rd, rp, lat);
    port_idle(1);
    chk("s1_rd_ack", 32'(av), 32'h2);
    chk("s1_rd_data", 32'(rd), 32'hA5);

    do_reset();
    ack_log.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          logic [1:0] a0; logic [7:0] r0, q0; int l0;
          port_do(0, 1, 8'h20, 8'h01, 0, a0, r0, q0, l0);
        end
        port_idle(0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          logic [1:0] a1; logic [7:0] r1, q1; int l1;
          port_do(1, 1, 8'h21, 8'h02, 0, a1, r1, q1, l1);
        end
        port_idle(1);
      end
    join
    chk("s2_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      chk($sformatf("s2_order%0d", i), 32'(ack_log[i]),
          (i % 2 == 1) ? 32'h2 : 32'h1);
    chk("s2_mem20", 32'(mem[8'h20]), 32'h01);
    chk("s2_mem21", 32'(mem[8'h21]), 32'h02);

    port_do(0, 1, 8'hFF, 8'h3C, 0, av, rd, rp, lat);
    port_idle(0);
    port_do(1, 0, 8'hFF, 8'h00, 0, av, rd, rp, lat);
    port_idle(1);
    chk("s3_rd", 32'(rd), 32'h3C);
    chk("s3_rd_prev", 32'(rp), 32'h00);
    port_do(0, 1, 8'h30, 8'h99, 0, av, rd, rp, lat);
    port_idle(0);
    chk("s3_rd_hold", 32'(rd), 32'h3C);

    port_do(0, 1, 8'h05, 8'h11, 0, av, rd, rp, lat);
    port_idle(0);
    p_we[0] = 1; p_addr[0] = 8'h05; p_wd[0] = 8'h77;
    p_req[0] = 1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; p_req[0] = 0;
    @(negedge clk);
    chk("s4_we_gated", 32'(bus.mem_we), 32'h0);
    chk("s4_no_ack", 32'(bus.ack), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("s4_busy", 32'(bus.busy), 32'h0);
    chk("s4_ack", 32'(bus.ack), 32'h0);
    chk("s4_rdata", 32'(bus.rdata), 32'h0);
    chk("s4_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("s4_mem5", 32'(mem[8'h05]), 32'h11);
    @(posedge clk); #1;
    port_do(1, 0, 8'h05, 8'h00, 0, av, rd, rp, lat);
    port_idle(1);
    chk("s4_rd5", 32'(rd), 32'h11);

`ifdef DMEM_ARB_LOCK_EN
    do_reset();
    ack_log.delete();
    fork
      begin
        logic [1:0] a1; logic [7:0] r1, q1; int l1;
        port_do(1, 0, 8'h40, 8'h00, 1, a1, r1, q1, l1);
        port_do(1, 1, 8'h40, 8'h5A, 0, a1, r1, q1, l1);
        port_idle(1);
      end
      begin
        logic [1:0] a0; logic [7:0] r0, q0; int l0;
        @(posedge clk); #1;
        port_do(0, 0, 8'h41, 8'h00, 0, a0, r0, q0, l0);
        port_do(0, 0, 8'h41, 8'h00, 0, a0, r0, q0, l0);
        port_idle(0);
      end
    join
    chk("lk_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() >= 3) begin
      chk("lk_first", 32'(ack_log[0]), 32'h2);
      chk("lk_second", 32'(ack_log[1]), 32'h2);
      chk("lk_third", 32'(ack_log[2]), 32'h1);
    end
    chk("lk_mem40", 32'(mem[8'h40]), 32'h5A);
`endif

    do_reset();
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) @(posedge clk);
    #1;
    nmis = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_final_mismatches", 32'(nmis), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port 256x8 data memory (clocked write, combinational read) between the core's load/store unit (port 0) and a host/loader port (port 1). It latches the winning command, drives the memory port for exactly one cycle, captures read data into a register, and acknowledges the owner. Priority is round-robin, so neither port starves. It sits between the requesters and the data memory instance.

## Interface
- AW, 8, address width; must match data memory depth (2^AW entries)
- DW, 8, data width
- clk  in  1  rising-edge clock; only clock in the block
- reset  in  1  synchronous, active-high reset
- req  in  2  per-port request; hold high with command stable until ack
- we  in  2  per-port write enable (1 = write, 0 = read)
- addr0, addr1  in  AW each  per-port address
- wdata0, wdata1  in  DW each  per-port write data
- ack  out  2  one-cycle completion pulse to the owner; one-hot or zero
- rdata  out  DW  registered read data; valid in the ack cycle; shared by both ports
- busy  out  1  high in ACCESS and DONE
- mem_we  out  1  to data memory write enable
- mem_addr  out  AW  to data memory address
- mem_di  out  DW  to data memory write data
- mem_dout  in  DW  from data memory combinational read

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, the picker selects the winner, latches owner, we, addr and wdata into cmd registers, then moves to ACCESS; otherwise stays in IDLE.
- Picker: if exactly one req is high, that port wins. If both are high, the port named by prio wins. prio resets to 0.
- ACCESS: mem_addr = cmd_addr, mem_di = cmd_wdata, mem_we = cmd_we & ~reset. The write commits at the closing edge. rdata <= mem_dout at the closing edge for reads only; writes leave rdata unchanged. Then move to DONE.
- DONE: ack[owner] = 1; prio <= ~owner; then move to IDLE.
- Requester rule: on the edge where its ack is high, a requester drops req or presents a new command. The arbiter never re-samples during DONE.
- mem_we is 0 in IDLE and DONE. mem_addr and mem_di hold the last cmd values outside ACCESS.
- A req that drops before ack is a protocol violation. A command already latched completes regardless.

## Timing
- Reset values: state = IDLE, ack = 0, rdata = 0, busy = 0, mem_we = 0, mem_addr = 0, mem_di = 0, prio = 0, cmd regs = 0.
- Latency: req sampled in IDLE at cycle T; memory access in T+1; ack and rdata in T+2.
- Throughput: one access per 3 cycles. A port that re-requests immediately is sampled at T+3.
- Both ports requesting continuously: grants alternate 0,1,0,1…, starting with 0 after reset.
- reset during ACCESS: the write is suppressed (mem_we gated), no ack is issued, and the FSM is in IDLE at the next cycle.
- reset during DONE: the ack pulse is dropped, and prio reverts to 0.
- Address wrap: not applicable. Addresses 0 and 2^AW-1 are ordinary.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - Adds input lock (2 bits). It is sampled with the winning req in IDLE and stored as cmd_lock.
  - In DONE with cmd_lock = 1, the arbiter sets locked, and the next IDLE considers only the owner's req; the other port waits.
  - locked clears when the owner completes a command with lock = 0. The owner dropping req does not clear it.
  - reset clears locked.
  - Purpose: atomic read-modify-write sequences.
- DMEM_ARB_LOCK_EN undefined: no lock port and pure round-robin behaviour.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t
  - typedef logic port_id_t (requester index)
  - localparam NREQ = 2
- Sub-module rr_arb2 is the combinational picker: inputs req[1:0], prio, and under the macro locked and owner; outputs a valid flag and the winner id.
- The top level holds the FSM, cmd registers, rdata and prio registers.

## Test plan
- Reset, then port 0 writes addr 0x10 data 0xA5 -> mem_we high only in the ACCESS cycle; ack = 01 two cycles after req; a later port 1 read of 0x10 returns rdata 0xA5 with ack = 10.
- Both ports request every cycle from reset: port 0 writes 0x01 at 0x20, port 1 writes 0x02 at 0x21 -> ack order 01, 10, 01, 10 and never simultaneous.
- Read of 0xFF after writing 0x3C there -> rdata = 0x3C exactly in the ack cycle; rdata unchanged across a following write.
- reset asserted in the ACCESS cycle of a write of 0x77 to 0x05 -> mem[0x05] unchanged, no ack, outputs at reset values.
- With DMEM_ARB_LOCK_EN: port 1 issues a locked read of 0x40 then an unlocked write of 0x40 while port 0 requests continuously -> both port 1 ops are acked before any port 0 ack.
